// File: rtl/router_flit_serializer_if.sv
// Flit-in / byte-out handshake bundle for router_flit_serializer.
// slave is the serializer side, master the router core and link side.
interface router_flit_serializer_if;
  logic [31:0] flit_in;
  logic        flit_wr;
  logic        flit_full;
  logic        flit_empty;
  logic        flit_overflow;
  logic [7:0]  byte_out;
  logic        byte_wr;
  logic        byte_full;
  logic        busy;

  modport slave (
    input  flit_in, flit_wr, byte_full,
    output flit_full, flit_empty, flit_overflow, byte_out, byte_wr, busy
  );

  modport master (
    output flit_in, flit_wr, byte_full,
    input  flit_full, flit_empty, flit_overflow, byte_out, byte_wr, busy
  );
endinterface

// File: rtl/router_flit_serializer.sv
// Buffers 32-bit flits and streams each one out as four bytes, LSB first,
// gated by the downstream full flag.
module router_flit_serializer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input logic                      clk,
  input logic                      rst,
  router_flit_serializer_if.slave  bus
);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         shift_q, shift_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic                byte_wr_q, byte_wr_d;
  logic                overflow_q;
  logic                full, empty, push, pop;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);
  // Acceptance looks only at the registered occupancy, so a same-edge pop never frees room.
  assign push  = bus.flit_wr & ~full;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    byte_out_d = byte_out_q;
    byte_wr_d  = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shift_d    = mem_q[rd_ptr_q];
          pop        = 1'b1;
          byte_idx_d = 2'd0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (!bus.byte_full) begin
          byte_wr_d  = 1'b1;
          byte_out_d = shift_q[{byte_idx_q, 3'b000} +: 8];
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Reload on the last byte so back-to-back flits leave no gap.
            if (!empty) begin
              shift_d = mem_q[rd_ptr_q];
              pop     = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      byte_idx_q <= 2'd0;
      shift_q    <= '0;
      byte_out_q <= 8'h00;
      byte_wr_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      byte_out_q <= byte_out_d;
      byte_wr_q  <= byte_wr_d;
      overflow_q <= bus.flit_wr & full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign bus.flit_full     = full;
  assign bus.flit_empty    = empty;
  assign bus.flit_overflow = overflow_q;
  assign bus.byte_out      = byte_out_q;
  assign bus.byte_wr       = byte_wr_q;
  assign bus.busy          = (state_q == StShift);

endmodule

// File: tb/tb_router_flit_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the flit buffer and byte stream.
module tb_router_flit_serializer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_flit_serializer_if bus ();

  router_flit_serializer #(
    .DEPTH  (DEPTH),
    .ADDR_W (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: pending flits, the flit on the wire and how many of its bytes are out.
  logic [31:0] q_buf[$];
  bit          cur_valid = 1'b0;
  logic [31:0] cur_flit  = '0;
  int          sent      = 0;
  logic        exp_wr    = 1'b0;
  logic        exp_ovf   = 1'b0;
  logic [7:0]  exp_out   = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    bit full_now;
    if (rst) begin
      q_buf.delete();
      cur_valid = 1'b0;
      sent      = 0;
      exp_wr    = 1'b0;
      exp_out   = 8'h00;
      exp_ovf   = 1'b0;
    end else begin
      full_now = (q_buf.size() == DEPTH);
      exp_ovf  = bus.flit_wr && full_now;
      exp_wr   = 1'b0;
      if (!cur_valid) begin
        if (q_buf.size() > 0) begin
          cur_flit  = q_buf.pop_front();
          sent      = 0;
          cur_valid = 1'b1;
        end
      end else if (!bus.byte_full) begin
        exp_wr  = 1'b1;
        exp_out = 8'(cur_flit >> (8 * sent));
        sent++;
        if (sent == 4) begin
          if (q_buf.size() > 0) begin
            cur_flit = q_buf.pop_front();
            sent     = 0;
          end else begin
            cur_valid = 1'b0;
          end
        end
      end
      if (bus.flit_wr && !full_now) q_buf.push_back(bus.flit_in);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("byte_wr",       {31'd0, bus.byte_wr},       {31'd0, exp_wr});
    check("byte_out",      {24'd0, bus.byte_out},      {24'd0, exp_out});
    check("flit_overflow", {31'd0, bus.flit_overflow}, {31'd0, exp_ovf});
    check("busy",          {31'd0, bus.busy},          {31'd0, cur_valid});
    check("flit_full",     {31'd0, bus.flit_full},     {31'd0, q_buf.size() == DEPTH});
    check("flit_empty",    {31'd0, bus.flit_empty},    {31'd0, q_buf.size() == 0});
  endtask

  task automatic drive(input bit r, input bit wr, input logic [31:0] d, input bit bf);
    rst          = r;
    bus.flit_wr  = wr;
    bus.flit_in  = d;
    bus.byte_full = bf;
    step();
  endtask

  task automatic idle(input int n, input bit bf);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, bf);
  endtask

  initial begin
    bus.flit_wr   = 1'b0;
    bus.flit_in   = '0;
    bus.byte_full = 1'b0;

    // Reset state
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    idle(2, 1'b0);

    // Single flit
    drive(1'b0, 1'b1, 32'h4433_2211, 1'b0);
    idle(8, 1'b0);

    // Fill behind a stalled link, overflow, then drain contiguously
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, {4{8'hA0 + 8'(i)}}, 1'b1);
    drive(1'b0, 1'b1, 32'hB0B0_B0B0, 1'b1);
    idle(26, 1'b0);

    // Stall after byte 1
    drive(1'b0, 1'b1, 32'hDDCC_BBAA, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    idle(6, 1'b0);

    // Paced writes, pointers wrap
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b0);
      idle(3, 1'b0);
    end
    idle(6, 1'b0);

    // Reset mid-flit with another flit buffered
    drive(1'b0, 1'b1, 32'h8765_4321, 1'b0);
    drive(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    idle(3, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    idle(8, 1'b0);
    drive(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    idle(7, 1'b0);

    // Keep writing into a full buffer while it drains; reload pops must not admit writes
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'h1111_0000 + 32'(i), 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 32'hC0C0_0000 + 32'(i), 1'b0);
    idle(24, 1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 40), $urandom(),
            ($urandom_range(0, 99) < 25));
    end
    idle(30, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
